// File: rtl/reset_pulse_gen_pkg.sv
// Shared encodings and default durations for the system reset pulse generator.
// The system controller imports the same constants so both ends agree on timing.
package reset_pulse_gen_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ASSERT  = ST_ASSERT,
    S_RELEASE = ST_RELEASE,
    S_HOLDOFF = ST_HOLDOFF
  } state_t;

  localparam int unsigned WARM_CYCLES_DEF     = 1024;
  localparam int unsigned COLD_CYCLES_DEF     = 2097152;
  localparam int unsigned RELEASE_TIMEOUT_DEF = 4096;
  localparam int unsigned HOLDOFF_CYCLES_DEF  = 256;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return (max_cycles > 1) ? $clog2(max_cycles) : 1;
  endfunction

  // A duration is loaded as (cycles - 1), so that value must fit in width bits.
  function automatic bit dur_fits(input int unsigned cycles, input int unsigned width);
    return (cycles >= 1) && ((64'(cycles) - 64'd1) < (64'd1 << width));
  endfunction

endpackage

// File: rtl/reset_pulse_gen_if.sv
// Reset request handshake between the host (master) and the pulse generator (slave).
interface reset_pulse_gen_if;
  logic req_valid;
  logic req_cold;
  logic req_ready;

  modport master (output req_valid, output req_cold, input req_ready);
  modport slave  (input req_valid, input req_cold, output req_ready);
endinterface

// File: rtl/reset_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input, with selectable reset value.
// Latency: 2 sysclk cycles from d to q.
// Backpressure: none, free-running sampler.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_pulse_gen.sv
// Drives the open-drain system reset line low for a warm/cold pulse and reports foreign pulses.
// Latency: line_drive rises the edge a request is accepted; busy spans pulse + release + hold-off.
// Backpressure: req_ready only in IDLE with the line sensed high; held requests wait.
module reset_pulse_gen
  import reset_pulse_gen_pkg::*;
#(
  parameter int unsigned WARM_CYCLES     = WARM_CYCLES_DEF,
  parameter int unsigned COLD_CYCLES     = COLD_CYCLES_DEF,
  parameter int unsigned RELEASE_TIMEOUT = RELEASE_TIMEOUT_DEF,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                sysclk,
  input  logic                reset_n,
  reset_pulse_gen_if.slave    req,
  input  logic                line_in,
  output logic                line_drive,
  output logic                busy,
  output logic                timeout,
  output logic                foreign_pulse
);

  localparam int unsigned CNT_W = cnt_width(COLD_CYCLES);
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam bit PARAMS_OK = dur_fits(WARM_CYCLES, CNT_W) && dur_fits(COLD_CYCLES, CNT_W) &&
                             dur_fits(RELEASE_TIMEOUT, CNT_W) && dur_fits(HOLDOFF_CYCLES, CNT_W) &&
                             (DEBOUNCE_CYCLES >= 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("reset_pulse_gen: a duration parameter is zero or does not fit the counter");
  end

  localparam logic [CNT_W-1:0] WARM_LD = CNT_W'(WARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] COLD_LD = CNT_W'(COLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LD  = CNT_W'(RELEASE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [DEB_W-1:0] deb_cnt;
  logic             line_s;
  logic             req_ready_int;

  // Resets to "released" so a reset of this block never looks like a foreign pulse.
  sync_2ff #(.RST_VAL(1'b1)) u_line_sync (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .d       (line_in),
    .q       (line_s)
  );

  assign req_ready_int = (state == S_IDLE) && line_s;
  assign req.req_ready = req_ready_int;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      deb_cnt       <= '0;
      line_drive    <= 1'b0;
      busy          <= 1'b0;
      timeout       <= 1'b0;
      foreign_pulse <= 1'b0;
    end else begin
      foreign_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!line_s) begin
            deb_cnt <= (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + 1'b1;
          end else begin
            foreign_pulse <= (deb_cnt == DEB_MAX);
            deb_cnt       <= '0;
          end
          if (req.req_valid && req_ready_int) begin
            cnt        <= req.req_cold ? COLD_LD : WARM_LD;
            timeout    <= 1'b0;
            line_drive <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          deb_cnt <= '0;
          if (cnt == '0) begin
            cnt        <= REL_LD;
            line_drive <= 1'b0;
            state      <= S_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          deb_cnt <= '0;
          // A line that never rises still moves on, flagging a stuck reset net.
          if (line_s) begin
            cnt   <= HOLD_LD;
            state <= S_HOLDOFF;
          end else if (cnt == '0) begin
            timeout <= 1'b1;
            cnt     <= HOLD_LD;
            state   <= S_HOLDOFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLDOFF: begin
          deb_cnt <= '0;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Bench for reset_pulse_gen: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_reset_pulse_gen;

  localparam int WARM = 8;
  localparam int COLD = 32;
  localparam int RT   = 16;
  localparam int HOLD = 4;
  localparam int DEB  = 4;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b1;
  logic ext_low = 1'b0;
  logic line_in;
  logic line_drive, busy, timeout, foreign_pulse;

  reset_pulse_gen_if rif ();

  always #5 sysclk = ~sysclk;

  // Open-drain line with pull-up: low if the DUT or any other agent pulls it.
  assign line_in = !(line_drive || ext_low);

  reset_pulse_gen #(
    .WARM_CYCLES     (WARM),
    .COLD_CYCLES     (COLD),
    .RELEASE_TIMEOUT (RT),
    .HOLDOFF_CYCLES  (HOLD),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .sysclk        (sysclk),
    .reset_n       (reset_n),
    .req           (rif),
    .line_in       (line_in),
    .line_drive    (line_drive),
    .busy          (busy),
    .timeout       (timeout),
    .foreign_pulse (foreign_pulse)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge sysclk) cyc <= cyc + 1;

  // Reference model: outputs after edge n are derived from the acceptance edge,
  // the edge the release phase ended, and a run-length of synchronised low samples.
  int acc_e, dur, rel_e, low_run;
  bit m_drive, m_busy, m_to, m_fp, m_ls, m_s1, m_ready;

  task automatic mdl_init();
    acc_e = -1; dur = 0; rel_e = -1; low_run = 0;
    m_drive = 0; m_busy = 0; m_to = 0; m_fp = 0;
    m_ls = 1; m_s1 = 1; m_ready = 1;
  endtask

  task automatic mdl_step();
    int n;
    bit fp_next;
    n = cyc + 1;
    fp_next = 0;
    if (!m_busy) begin
      if (!m_ls) low_run++;
      else begin
        fp_next = (low_run >= DEB);
        low_run = 0;
      end
      if (rif.req_valid && m_ls) begin
        acc_e = n; dur = rif.req_cold ? COLD : WARM; rel_e = -1; m_to = 0;
      end
    end else begin
      low_run = 0;
      if (rel_e < 0 && n > acc_e + dur) begin
        if (m_ls) rel_e = n;
        else if (n == acc_e + dur + RT) begin
          rel_e = n; m_to = 1;
        end
      end
    end
    m_drive = (acc_e >= 0) && (n >= acc_e) && (n < acc_e + dur);
    m_busy  = (acc_e >= 0) && (n >= acc_e) && ((rel_e < 0) || (n < rel_e + HOLD));
    m_fp    = fp_next;
    m_ls    = m_s1;
    m_s1    = line_in;
    m_ready = !m_busy && m_ls;
  endtask

  initial mdl_init();

  always @(negedge sysclk) begin
    if (!reset_n) mdl_init();
    chk("mdl_line_drive", line_drive, m_drive);
    chk("mdl_busy", busy, m_busy);
    chk("mdl_timeout", timeout, m_to);
    chk("mdl_foreign_pulse", foreign_pulse, m_fp);
    chk("mdl_req_ready", rif.req_ready, m_ready);
    if (reset_n) mdl_step();
  end

  // Event monitors used by the directed checks.
  int drv_cnt = 0, fp_cnt = 0, fp_last = -1, to_first = -1;
  always @(negedge sysclk) begin
    if (line_drive === 1'b1) drv_cnt++;
    if (foreign_pulse === 1'b1) begin fp_cnt++; fp_last = cyc; end
    if (timeout === 1'b1 && to_first < 0) to_first = cyc;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic send_req(input logic cold, input int budget, output int acc);
    acc = -1;
    rif.req_valid = 1'b1;
    rif.req_cold  = cold;
    for (int i = 0; i < budget && acc < 0; i++) begin
      @(negedge sysclk);
      if (rif.req_ready) begin
        @(posedge sysclk);
        #1;
        acc = cyc;
      end
    end
    if (acc < 0) tick();
    rif.req_valid = 1'b0;
    chk("req_accepted", (acc >= 0), 1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (!busy) break;
    end
    chk("wait_idle_in_budget", (i < budget), 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, r, t;
    rif.req_valid = 1'b0;
    rif.req_cold  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_drive", line_drive, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_ready_line_high", rif.req_ready, 1);

    // Warm pulse with the line following line_drive.
    drv_cnt = 0;
    send_req(1'b0, 20, acc);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sysclk);
      if (t < 0 && !busy) t = cyc;
    end
    tick();
    chk("warm_drive_len", drv_cnt, 8);
    chk("warm_busy_fall", t - acc, 8 + 2 + 4 + 1);
    chk("warm_timeout", timeout, 0);

    // Two cold requests back to back: IDLE returns 39 cycles after the first
    // acceptance and the held request is taken on the following edge.
    drv_cnt = 0;
    send_req(1'b1, 20, acc);
    send_req(1'b1, 100, acc2);
    chk("b2b_spacing", acc2 - acc, 32 + 2 + 4 + 1 + 1);
    chk("cold1_drive_len", drv_cnt, 32);
    drv_cnt = 0;
    wait_idle(100);
    chk("cold2_drive_len", drv_cnt, 32);

    // Line stuck low after release.
    to_first = -1;
    send_req(1'b0, 20, acc);
    ext_low = 1'b1;
    wait_idle(100);
    chk("stuck_timeout_at", to_first - acc, 8 + 16);
    repeat (3) tick();
    chk("stuck_busy", busy, 0);
    chk("stuck_ready", rif.req_ready, 0);
    chk("stuck_timeout_sticky", timeout, 1);
    ext_low = 1'b0;
    repeat (8) tick();

    // Qualified foreign pulse, then a short glitch.
    fp_cnt = 0;
    ext_low = 1'b1;
    repeat (4) tick();
    chk("foreign_ready_low", rif.req_ready, 0);
    repeat (6) tick();
    ext_low = 1'b0;
    r = cyc;
    repeat (8) tick();
    chk("foreign_count", fp_cnt, 1);
    chk("foreign_delay", fp_last - r, 3);
    fp_cnt = 0;
    ext_low = 1'b1;
    repeat (3) tick();
    ext_low = 1'b0;
    repeat (8) tick();
    chk("glitch_count", fp_cnt, 0);

    // Reset mid-ASSERT: line_drive must drop before any clock edge.
    drv_cnt = 0;
    send_req(1'b1, 20, acc);
    repeat (5) tick();
    chk("pre_reset_drive", line_drive, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_drive", line_drive, 0);
    chk("async_reset_busy", busy, 0);
    chk("async_reset_timeout", timeout, 0);
    chk("async_reset_fp", foreign_pulse, 0);
    @(posedge sysclk);
    #1 reset_n = 1'b1;
    drv_cnt = 0;
    repeat (40) tick();
    chk("no_resume_after_reset", drv_cnt, 0);

    // Request raised during a foreign low waits for the line, then runs normally.
    ext_low = 1'b1;
    repeat (3) tick();
    rif.req_valid = 1'b1;
    rif.req_cold  = 1'b0;
    repeat (8) tick();
    chk("held_req_ready", rif.req_ready, 0);
    chk("held_req_busy", busy, 0);
    fp_cnt = 0;
    drv_cnt = 0;
    ext_low = 1'b0;
    r = cyc;
    send_req(1'b0, 20, acc);
    chk("held_req_accept", acc - r, 3);
    wait_idle(50);
    repeat (6) tick();
    chk("held_req_drive_len", drv_cnt, 8);
    chk("held_req_fp_once", fp_cnt, 1);
    chk("held_req_fp_is_foreign", fp_last - acc, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
